fmap_stream_reader: RTL and testbench
=====================================

# fmap_stream_reader

- Read-side sequencer for the six on-chip feature-map channel buffers.
- On `start`, scans one frame in raster order and drives a single shared read address into all six buffers' read ports. Each buffer returns data one cycle after the address is presented (synchronous read).
- Re-times that read data into a backpressured valid/ready pixel stream carrying all six channels per beat.
- Sits between the channel buffer controller and the next CNN layer or pooling stage.

## Interface
Parameters:
- `ADDR_W`, 14, buffer address width
- `DATA_W`, 8, bits per channel sample
- `NUM_CH`, 6, channels per beat
- `IMG_W`, 128, frame width in pixels
- `IMG_H`, 128, frame height; `IMG_W*IMG_H` must be ≤ 2^ADDR_W

Ports:
- `clk`  in  1  single clock; all logic on its rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  pulse; begins a frame scan; ignored while `busy`=1
- `busy`  out  1  high from the cycle after `start` is accepted until `done`
- `done`  out  1  one-cycle pulse after the final beat handshake
- `rd_addr`  out  ADDR_W  shared read address fanned to every channel buffer's read address
- `rd_data`  in  NUM_CH*DATA_W  buffer read data concatenated; ch1 in bits [DATA_W-1:0], ch6 in MSBs
- `m_valid`  out  1  output beat valid
- `m_ready`  in  1  downstream accept
- `m_data`  out  NUM_CH*DATA_W  pixel, same packing as `rd_data`
- `m_eol`  out  1  beat is the last column of a row
- `m_last`  out  1  beat is the final pixel of the frame

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE→RUN when `start`=1. On this transition: address counter ← 0, `busy` ← 1.
  - RUN→DRAIN on the cycle that issues address `NPIX-1`, where `NPIX=IMG_W*IMG_H`.
  - DRAIN→IDLE on the handshake of the beat with `m_last`=1. On this transition: `done` ← 1 for one cycle, `busy` ← 0.
- Issue rule:
  - `pop = m_valid & m_ready`.
  - `occ = fifo_count + inflight`, where `inflight` is a 1-bit register set by the previous cycle's issue.
  - `issue = (state==RUN) & (occ - pop < 2)`.
  - On issue, the address counter increments. `rd_addr` equals the counter, held stable when not issuing.
  - `issue` may depend combinationally on `m_ready`.
- Return path:
  - When `inflight`=1, `rd_data` is written into a 2-entry FIFO at the next clock edge.
  - The FIFO head drives `m_data`, `m_eol` and `m_last`.
  - `m_valid` = FIFO not empty.
  - Row/column tags are tracked alongside each issued address and travel with the data through `inflight` and the FIFO.
- The FIFO never overflows and no read is dropped: the issue rule guarantees `occ` ≤ 2.
- `start` while `busy`: ignored, with no effect on the current scan.
- Beat ordering: `m_data`/flags must stay stable while `m_valid`=1 and `m_ready`=0. Beats are emitted in address order 0..NPIX-1 exactly once.
- `IMG_W`=1: every beat has `m_eol`=1.
- Frame of one pixel (`NPIX`=1): RUN lasts one cycle; that single beat has `m_last`=1 and `m_eol`=1.
- `rst` asserted mid-scan: asynchronously clears FSM, counters, `inflight` and FIFO. No `done` pulse; outputs return to their reset values.

## Timing
- Reset values: `busy`=0, `done`=0, `m_valid`=0, `m_data`=0, `m_eol`=0, `m_last`=0, `rd_addr`=0; state IDLE.
- Startup sequence, with `start` sampled at edge E0:
  - `rd_addr`=0 during E0→E1.
  - Buffer data is valid E1→E2.
  - FIFO captures it at E2, so `m_valid`=1 from E2 (latency 2 cycles).
- Throughput: with `m_ready` held high, one beat per cycle with no bubbles.
  - Last beat is handshaken in cycle E(NPIX+1)→E(NPIX+2).
  - `done` is high in the following cycle.
  - `start` is accepted again the cycle after `done`.
- Backpressure: a read already in flight when `m_ready` drops lands in the FIFO; no further issue occurs while `occ` would exceed 2. After `m_ready` rises, the beat stream resumes on the same cycle.

## Test plan
Bench configuration: `IMG_W`=4, `IMG_H`=3 (NPIX=12). The buffer model returns byte `(16*k + addr) & 0xFF` for channel k=0..5, with one-cycle read latency.

- **Reset/idle:** hold `rst`=0 for 3 cycles, then release with no `start` → all outputs stay at reset values for 20 cycles.
- **Full-rate frame:** `start` pulse, `m_ready`=1 → `m_valid` rises 2 cycles after start.
  - 12 consecutive beats; beat n ch1 byte = n, ch6 byte = 80+n.
  - `m_eol` on beats 3, 7, 11; `m_last` on beat 11 only.
  - `done` pulses the cycle after beat 11.
- **Backpressure:** `m_ready` toggles pseudo-randomly (≈50%) → the same 12 beats in order, no drops or duplicates.
  - `m_data` is stable during every stall.
  - `occ` never exceeds 2.
- **Start while busy:** second `start` pulse at beat 5 → ignored; exactly 12 beats and one `done`.
- **Reset mid-frame:** assert `rst` at beat 6 → `m_valid`/`busy` drop immediately, no `done`.
  - A new `start` after release yields a complete frame beginning at address 0.
- **Back-to-back frames:** `start` on the cycle after `done` → second frame starts with data identical to the first, beginning at address 0.

Source files
------------

// File: rtl/fmap_stream_reader.sv
// fmap_stream_reader: raster-order read sequencer for the feature-map
// channel buffers. It drives one shared read address into all channel
// buffers and re-times their one-cycle-latency read data into a
// backpressured valid/ready pixel stream (all channels per beat).
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start           pulse, begins a frame scan (ignored while busy)
//   busy, done      scan in progress / one-cycle end-of-frame pulse
//   rd_addr         shared buffer read address
//   rd_data         buffer read data, ch1 in the LSBs
//   m_valid/ready   output beat handshake
//   m_data          pixel, same packing as rd_data
//   m_eol, m_last   last column of a row / last pixel of the frame
module fmap_stream_reader #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8,
    parameter int NUM_CH = 6,
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [ADDR_W-1:0]        rd_addr,
    input  logic [NUM_CH*DATA_W-1:0] rd_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [NUM_CH*DATA_W-1:0] m_data,
    output logic                     m_eol,
    output logic                     m_last
);

    localparam int PW = NUM_CH * DATA_W;
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [CW-1:0]       r_col;
    logic [RW-1:0]       r_row;
    logic                r_busy;
    logic                r_done;

    // Read issued last cycle; its data is on rd_data this cycle.
    logic                r_inflight;
    logic                r_if_eol;
    logic                r_if_last;

    // Two-entry return FIFO: data plus the position tags of each beat.
    logic [1:0][PW-1:0]  r_mem;
    logic [1:0]          r_eol_q;
    logic [1:0]          r_last_q;
    logic                r_wp;
    logic                r_rp;
    logic [1:0]          r_cnt;

    logic                w_pop;
    logic [2:0]          w_occ;
    logic                w_issue;
    logic                w_tag_eol;
    logic                w_tag_last;

    assign w_pop      = m_valid & m_ready;
    assign w_occ      = {1'b0, r_cnt} + {2'b00, r_inflight};
    // A slot freed by this cycle's pop may be reused by this cycle's
    // issue, so full-rate streaming has no bubbles.
    assign w_issue    = (r_state == RUN) &&
                        ((w_occ - {2'b00, w_pop}) < 3'd2);
    assign w_tag_eol  = (r_col == COL_MAX);
    assign w_tag_last = w_tag_eol && (r_row == ROW_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_inflight <= 1'b0;
            r_if_eol   <= 1'b0;
            r_if_last  <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_if_eol  <= w_tag_eol;
                r_if_last <= w_tag_last;
            end
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= RUN;
                        r_addr  <= '0;
                        r_col   <= '0;
                        r_row   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_issue) begin
                        r_addr <= r_addr + ADDR_W'(1);
                        if (w_tag_eol) begin
                            r_col <= '0;
                            r_row <= r_row + RW'(1);
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                        if (w_tag_last) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_pop && m_last) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem    <= '0;
            r_eol_q  <= '0;
            r_last_q <= '0;
            r_wp     <= 1'b0;
            r_rp     <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (r_inflight) begin
                r_mem[r_wp]    <= rd_data;
                r_eol_q[r_wp]  <= r_if_eol;
                r_last_q[r_wp] <= r_if_last;
                r_wp           <= ~r_wp;
            end
            if (w_pop) begin
                r_rp <= ~r_rp;
            end
            r_cnt <= r_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign rd_addr = r_addr;
    assign m_valid = (r_cnt != 2'd0);
    assign m_data  = r_mem[r_rp];
    assign m_eol   = r_eol_q[r_rp];
    assign m_last  = r_last_q[r_rp];

endmodule

// File: tb/tb_fmap_stream_reader.sv
// Testbench for fmap_stream_reader on a 4x3 frame with a one-cycle
// latency buffer model returning (16*k + addr) & 0xFF on channel k.
module tb_fmap_stream_reader;

    localparam int AW = 14;
    localparam int DW = 8;
    localparam int NC = 6;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int NP = W * H;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic            busy;
    logic            done;
    logic [AW-1:0]   rd_addr;
    logic [NC*DW-1:0] rd_data = '0;
    logic            m_valid;
    logic            m_ready = 1'b0;
    logic [NC*DW-1:0] m_data;
    logic            m_eol;
    logic            m_last;

    int n_chk = 0;
    int n_err = 0;

    fmap_stream_reader #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_CH(NC),
        .IMG_W(W), .IMG_H(H)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .busy(busy), .done(done),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_eol(m_eol), .m_last(m_last)
    );

    always #5 clk = ~clk;

    // Channel buffer model: synchronous read, one cycle latency.
    always @(posedge clk) begin
        for (int k = 0; k < NC; k++)
            rd_data[k*DW +: DW] <= 8'((16 * k + int'(rd_addr)) & 255);
    end

    task automatic chk(input string tag,
                       input logic [79:0] obs,
                       input logic [79:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NC*DW-1:0] pix(input int n);
        logic [NC*DW-1:0] p;
        for (int k = 0; k < NC; k++)
            p[k*DW +: DW] = 8'((16 * k + n) & 255);
        return p;
    endfunction

    // Runs one frame: start pulse in the next cycle, then monitors
    // beats until done. bp: random m_ready; kick: beat index at which
    // a stray start is pulsed (-1: none); tail: idle cycles checked.
    task automatic frame(input string nm, input bit bp,
                         input int kick, input int tail);
        int beat = 0;
        int cyc = 0;
        int hs_cyc = -10;
        int occ;
        bit seen = 0;
        bit kicked = 0;
        logic pv = 0, pr = 0, peol = 0, plast = 0;
        logic [NC*DW-1:0] pd = '0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({nm, "/addr0"}, rd_addr, 0);
        while (!seen) begin
            start = 1'b0;
            if (cyc < 2)
                chk({nm, "/lat_lo"}, m_valid, 0);
            else if (cyc == 2)
                chk({nm, "/lat_hi"}, m_valid, 1);
            if (pv && !pr) begin
                chk({nm, "/stall_v"}, m_valid, 1);
                chk({nm, "/stall_d"}, {m_data, m_eol, m_last},
                    {pd, peol, plast});
            end
            occ = int'(dut.r_cnt) + int'(dut.r_inflight);
            chk({nm, "/occ"}, (occ <= 2), 1);
            if (done) begin
                seen = 1;
                chk({nm, "/done_at"}, cyc, hs_cyc + 1);
                chk({nm, "/beats"}, beat, NP);
                chk({nm, "/busy_lo"}, busy, 0);
            end else begin
                chk({nm, "/busy"}, busy, 1);
                m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                if (kick >= 0 && beat == kick && !kicked) begin
                    start = 1'b1;
                    kicked = 1;
                end
                if (m_valid && m_ready) begin
                    chk({nm, "/data"}, m_data, pix(beat));
                    chk({nm, "/eol"}, m_eol, (beat % W) == W - 1);
                    chk({nm, "/last"}, m_last, beat == NP - 1);
                    hs_cyc = cyc;
                    beat++;
                end
                pv = m_valid;
                pr = m_ready;
                pd = m_data;
                peol = m_eol;
                plast = m_last;
                cyc++;
                if (cyc > 400) begin
                    chk({nm, "/timeout"}, 0, 1);
                    seen = 1;
                end
                @(negedge clk);
            end
        end
        start = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < tail; i++) begin
            @(negedge clk);
            chk({nm, "/tail"}, {done, m_valid, busy}, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int beat;
        int cyc;

        // Reset and idle.
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst", {busy, done, m_valid, m_eol, m_last,
                        m_data, rd_addr}, 0);
        end
        rst = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("idle", {busy, done, m_valid, m_eol, m_last,
                         m_data, rd_addr}, 0);
        end

        frame("full", 1'b0, -1, 6);
        frame("bp", 1'b1, -1, 6);
        frame("kick", 1'b0, 5, 6);

        // Reset asserted mid-frame after six beats.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m_ready = 1'b1;
        beat = 0;
        cyc = 0;
        while (beat < 6 && cyc < 100) begin
            if (m_valid && m_ready) beat++;
            cyc++;
            @(negedge clk);
        end
        chk("mid/reach", beat, 6);
        rst = 1'b0;
        #1;
        chk("mid/clear", {busy, done, m_valid, m_eol, m_last,
                          m_data, rd_addr}, 0);
        repeat (3) begin
            @(negedge clk);
            chk("mid/nodone", {done, busy, m_valid}, 0);
        end
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("mid/idle", {done, busy, m_valid}, 0);
        end
        frame("after_rst", 1'b0, -1, 3);

        // Back-to-back frames.
        frame("b2b_a", 1'b0, -1, 0);
        frame("b2b_b", 1'b0, -1, 6);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
